// File: rtl/plotter_motion_reader.sv
// rtl/plotter_motion_reader.sv - two-axis DDA step/dir move executor with status write-back
module plotter_motion_reader #(
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned MIN_PERIOD  = 8,
  parameter logic [4:0]  STATUS_REG  = 5'd4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] reg_cmd,
  input  logic [31:0] reg_dx,
  input  logic [31:0] reg_dy,
  input  logic [31:0] reg_period,
  output logic        step_x,
  output logic        dir_x,
  output logic        step_y,
  output logic        dir_y,
  output logic        busy,
  output logic        io_we,
  output logic [4:0]  io_wreg,
  output logic [31:0] io_wdata,
  input  logic        io_ack
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_WB} state_t;

  state_t      state_q, state_d;
  logic        go_prev_q, go_prev_d;
  logic        armed_q, armed_d;
  logic [31:0] ax_q, ax_d, ay_q, ay_d;
  logic [31:0] major_q, major_d, per_q, per_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [32:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [31:0] k_q, k_d, t_q, t_d;
  logic        flag_x_q, flag_x_d, flag_y_q, flag_y_d;

  logic        start;
  logic [31:0] abs_x, abs_y;
  logic [32:0] sum_x, sum_y;
  logic        unused_cmd;

  assign unused_cmd = ^reg_cmd[31:1];

  // armed_q blocks a go that was already high across reset from looking like a fresh edge
  assign start = reg_cmd[0] & ~go_prev_q & armed_q;
  assign abs_x = reg_dx[31] ? (32'd0 - reg_dx) : reg_dx;
  assign abs_y = reg_dy[31] ? (32'd0 - reg_dy) : reg_dy;
  assign sum_x = acc_x_q + {1'b0, ax_q};
  assign sum_y = acc_y_q + {1'b0, ay_q};

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q   <= S_IDLE;
      go_prev_q <= 1'b0;
      armed_q   <= 1'b0;
      ax_q      <= '0;
      ay_q      <= '0;
      major_q   <= '0;
      per_q     <= '0;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      k_q       <= '0;
      t_q       <= '0;
      flag_x_q  <= 1'b0;
      flag_y_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_prev_q <= go_prev_d;
      armed_q   <= armed_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      major_q   <= major_d;
      per_q     <= per_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      k_q       <= k_d;
      t_q       <= t_d;
      flag_x_q  <= flag_x_d;
      flag_y_q  <= flag_y_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    go_prev_d = reg_cmd[0];
    armed_d   = armed_q | ~reg_cmd[0];
    ax_d      = ax_q;
    ay_d      = ay_q;
    major_d   = major_q;
    per_d     = per_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    acc_x_d   = acc_x_q;
    acc_y_d   = acc_y_q;
    k_d       = k_q;
    t_d       = t_q;
    flag_x_d  = flag_x_q;
    flag_y_d  = flag_y_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        ax_d     = abs_x;
        ay_d     = abs_y;
        major_d  = (abs_x > abs_y) ? abs_x : abs_y;
        per_d    = (reg_period > MIN_PERIOD) ? reg_period : MIN_PERIOD;
        dir_x_d  = ~reg_dx[31];
        dir_y_d  = ~reg_dy[31];
        acc_x_d  = '0;
        acc_y_d  = '0;
        k_d      = '0;
        t_d      = '0;
        flag_x_d = 1'b0;
        flag_y_d = 1'b0;
        state_d  = (major_d != 32'd0) ? S_RUN : S_WB;
      end
      S_RUN: begin
        // One DDA update per tick; the flags then gate the pulse window for the rest of it
        if (t_q == 32'd0) begin
          flag_x_d = (sum_x >= {1'b0, major_q});
          acc_x_d  = flag_x_d ? (sum_x - {1'b0, major_q}) : sum_x;
          flag_y_d = (sum_y >= {1'b0, major_q});
          acc_y_d  = flag_y_d ? (sum_y - {1'b0, major_q}) : sum_y;
        end
        if (t_q == per_q - 32'd1) begin
          k_d = k_q + 32'd1;
          t_d = '0;
          if (k_d == major_q) state_d = S_WB;
        end else begin
          t_d = t_q + 32'd1;
        end
      end
      S_WB: begin
        if (io_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_x   = 1'b0;
    step_y   = 1'b0;
    busy     = (state_q != S_IDLE);
    dir_x    = dir_x_q;
    dir_y    = dir_y_q;
    io_we    = 1'b0;
    io_wreg  = 5'd0;
    io_wdata = 32'd0;
    if (state_q == S_RUN && t_q >= 32'd1 && t_q <= PULSE_WIDTH) begin
      step_x = flag_x_q;
      step_y = flag_y_q;
    end
    if (state_q == S_WB) begin
      io_we    = 1'b1;
      io_wreg  = STATUS_REG;
      io_wdata = 32'd1;
    end
  end

endmodule

// File: tb/tb_plotter_motion_reader.sv
// tb/tb_plotter_motion_reader.sv - directed self-checking bench for plotter_motion_reader
module tb_plotter_motion_reader;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic [31:0] reg_cmd, reg_dx, reg_dy, reg_period;
  logic        step_x, dir_x, step_y, dir_y, busy, io_we, io_ack;
  logic [4:0]  io_wreg;
  logic [31:0] io_wdata;

  int checks = 0;
  int errors = 0;

  int          cyc, hx, hy, mis;
  logic [31:0] mx, my;
  logic        dxo, dyo;

  always #5 clock = ~clock;

  plotter_motion_reader dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .reg_cmd(reg_cmd), .reg_dx(reg_dx),
    .reg_dy(reg_dy), .reg_period(reg_period), .step_x(step_x), .dir_x(dir_x),
    .step_y(step_y), .dir_y(dir_y), .busy(busy), .io_we(io_we), .io_wreg(io_wreg),
    .io_wdata(io_wdata), .io_ack(io_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raises go and samples each falling edge until io_we (or the budget runs out).
  // Negedge n=1 is LOAD, n=2 is RUN t=0, so a step for tick j rises at n = j*per+3.
  task automatic run_move(input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] pr,
                          input int per_eff);
    logic px, py;
    px = 0; py = 0; mx = 0; my = 0; hx = 0; hy = 0; mis = 0; cyc = 0; dxo = 0; dyo = 0;
    reg_dx = dx; reg_dy = dy; reg_period = pr; reg_cmd = 32'h1;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clock);
      cyc = n;
      if (n == 2) begin dxo = dir_x; dyo = dir_y; end
      if (step_x) hx++;
      if (step_y) hy++;
      if (step_x && !px) begin
        if ((n - 3) % per_eff != 0) mis++;
        else if ((n - 3) / per_eff < 32) mx[(n - 3) / per_eff] = 1'b1;
      end
      if (step_y && !py) begin
        if ((n - 3) % per_eff != 0) mis++;
        else if ((n - 3) / per_eff < 32) my[(n - 3) / per_eff] = 1'b1;
      end
      px = step_x; py = step_y;
      if (io_we) break;
    end
  endtask

  task automatic check_move(input string tag, input int ecyc, input logic [31:0] emx,
                            input logic [31:0] emy, input int ehx, input int ehy,
                            input logic edx, input logic edy);
    chk({tag, "_cycles"}, cyc, ecyc);
    chk({tag, "_xmask"}, mx, emx);
    chk({tag, "_ymask"}, my, emy);
    chk({tag, "_xhigh"}, hx, ehx);
    chk({tag, "_yhigh"}, hy, ehy);
    chk({tag, "_misaligned"}, mis, 0);
    chk({tag, "_dirx"}, {31'd0, dxo}, {31'd0, edx});
    chk({tag, "_diry"}, {31'd0, dyo}, {31'd0, edy});
    chk({tag, "_wreg"}, {27'd0, io_wreg}, 32'd4);
    chk({tag, "_wdata"}, io_wdata, 32'd1);
  endtask

  task automatic ack_done(input string tag);
    io_ack = 1'b1;
    @(negedge clock);
    chk({tag, "_busy_after_ack"}, {31'd0, busy}, 32'd0);
    chk({tag, "_we_after_ack"}, {31'd0, io_we}, 32'd0);
    chk({tag, "_wreg_after_ack"}, {27'd0, io_wreg}, 32'd0);
    io_ack = 1'b0;
    reg_cmd = 32'h0;
    @(negedge clock);
  endtask

  initial begin
    ctrl_reset = 1'b1; reg_cmd = 0; reg_dx = 0; reg_dy = 0; reg_period = 0; io_ack = 0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_outs", {26'd0, step_x, dir_x, step_y, dir_y, io_we, 1'b0}, 32'd0);
    chk("reset_wdata", io_wdata, 32'd0);
    @(negedge clock);
    ctrl_reset = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // 1: single-axis move
    run_move(32'd3, 32'd0, 32'd10, 10);
    check_move("t1", 32, 32'b111, 32'b0, 12, 0, 1'b1, 1'b1);
    ack_done("t1");

    // 2: negative X, Y on ticks 2 and 4
    run_move(-32'sd4, 32'd2, 32'd8, 8);
    check_move("t2", 34, 32'b1111, 32'b1010, 16, 8, 1'b0, 1'b1);
    ack_done("t2");

    // 3: zero move goes straight to write-back
    run_move(32'd0, 32'd0, 32'd10, 10);
    check_move("t3", 2, 32'b0, 32'b0, 0, 0, 1'b1, 1'b1);
    ack_done("t3");

    // 4: period clamp
    run_move(32'd2, -32'sd2, 32'd2, 8);
    check_move("t4", 18, 32'b11, 32'b11, 8, 8, 1'b1, 1'b0);
    ack_done("t4");

    // minor X axis with Y major
    run_move(32'd1, -32'sd3, 32'd8, 8);
    check_move("t4b", 26, 32'b100, 32'b111, 4, 12, 1'b1, 1'b0);
    ack_done("t4b");

    // 5: reset mid-run with go held high
    reg_dx = 32'd5; reg_dy = 32'd0; reg_period = 32'd10; reg_cmd = 32'h1;
    repeat (4) @(negedge clock);
    chk("t5_step_before_reset", {31'd0, step_x}, 32'd1);
    #1 ctrl_reset = 1'b1;
    #1;
    chk("t5_busy_in_reset", {31'd0, busy}, 32'd0);
    chk("t5_outs_in_reset", {27'd0, step_x, dir_x, step_y, dir_y, io_we}, 32'd0);
    @(negedge clock);
    ctrl_reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("t5_no_retrigger", {31'd0, busy}, 32'd0);
    reg_cmd = 32'h0;
    @(negedge clock);
    run_move(32'd5, 32'd0, 32'd10, 10);
    check_move("t5", 52, 32'b11111, 32'b0, 20, 0, 1'b1, 1'b1);
    ack_done("t5");

    // 6: go toggles during RUN and WB, ack withheld
    reg_dx = 32'd2; reg_dy = 32'd1; reg_period = 32'd8; reg_cmd = 32'h1;
    cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clock);
      cyc = n;
      if (n == 5) reg_cmd = 32'h0;
      if (n == 8) reg_cmd = 32'h1;
      if (io_we) break;
    end
    chk("t6_cycles", cyc, 18);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t6_we_hold", {31'd0, io_we}, 32'd1);
      chk("t6_wreg_hold", {27'd0, io_wreg}, 32'd4);
      chk("t6_wdata_hold", io_wdata, 32'd1);
      reg_cmd = (i % 2 == 0) ? 32'h0 : 32'h1;
    end
    reg_cmd = 32'h1;
    io_ack = 1'b1;
    @(negedge clock);
    io_ack = 1'b0;
    chk("t6_busy_after_ack", {31'd0, busy}, 32'd0);
    chk("t6_we_after_ack", {31'd0, io_we}, 32'd0);
    repeat (3) @(negedge clock);
    chk("t6_stays_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plotter_motion_reader.md
Name: plotter_motion_reader

Overview:
Reads the command registers exposed by the processor register file and executes one two-axis relative move. It generates step/dir pulses for the X and Y stepper drivers, using a DDA (Bresenham-style) interpolator so both axes finish together. On completion it issues a write request back into the register file's external write port to post a done status. It sits between the CPU register outputs and the motor driver pins.

Parameters:
PULSE_WIDTH, 4, cycles each step pulse is held high
MIN_PERIOD, 8, minimum cycles per interpolation tick; must be >= PULSE_WIDTH+2
STATUS_REG, 5'd4, register index written with completion status

Ports:
clock  in  1  system clock, rising edge
ctrl_reset  in  1  asynchronous, active-high reset
reg_cmd  in  32  command word; bit0 = go, bits[31:1] ignored
reg_dx  in  32  signed relative X step count
reg_dy  in  32  signed relative Y step count
reg_period  in  32  unsigned cycles per tick
step_x  out  1  X step pulse
dir_x  out  1  X direction, 1 = positive
step_y  out  1  Y step pulse
dir_y  out  1  Y direction, 1 = positive
busy  out  1  high in LOAD, RUN and WB
io_we  out  1  status write request to register file
io_wreg  out  5  status register index; equals STATUS_REG when io_we = 1, else 0
io_wdata  out  32  status data; 32'd1 when io_we = 1, else 0
io_ack  in  1  write accepted by register-file arbiter

Behaviour:
- Reset (async): FSM = IDLE, every output 0, go_prev = 0, all internal counters and accumulators 0.
- go_prev is a register updated every cycle with reg_cmd[0], in every state.
- A start event is reg_cmd[0]=1 && go_prev=0. It is acted on only in IDLE; edges in other states are ignored.
- Holding go high after a move does not retrigger; a 0 must be sampled first.
- States: IDLE -> LOAD on start event. LOAD -> RUN if major != 0, else LOAD -> WB. RUN -> WB after the last tick completes. WB -> IDLE at the clock edge where io_ack = 1.
- LOAD (1 cycle) latches the following:
  - ax = |reg_dx|, ay = |reg_dy|, computed as 32-bit unsigned; -2^31 gives 2^31.
  - major = max(ax, ay).
  - per = max(reg_period, MIN_PERIOD).
  - dir_x = (reg_dx >= 0), dir_y = (reg_dy >= 0).
  - acc_x = acc_y = 0 (33-bit); tick counter k = 0; phase t = 0.
- Register inputs are ignored outside LOAD; changes during RUN have no effect.
- dir outputs are valid from the edge ending LOAD and hold until the next LOAD or reset. They are therefore stable >= 1 cycle before any step rises.
- RUN: phase counter t runs 0 .. per-1.
  - At t=0 of each tick, evaluate acc_x + ax. If the sum >= major, set the X step flag for this tick and store the sum - major; else store the sum. Y uses ay and acc_y identically.
  - step_x is high when the X flag is set and t is in [1, PULSE_WIDTH]; otherwise low. step_y likewise.
  - At t=per-1: k increments. If k reaches major, go to WB; else t wraps to 0.
  - RUN lasts exactly major*per cycles. The major axis steps every tick; the minor axis steps exactly min(ax, ay) times.
- WB: io_we = 1, io_wreg = STATUS_REG, io_wdata = 32'd1.
  - These are held constant until io_ack is sampled high.
  - io_ack outside WB is ignored.
  - The next cycle is IDLE with io_we = 0 and busy = 0.
- Reset mid-operation: outputs drop to 0 immediately (async). A held-high go requires a 0->1 transition to restart.
- Step pulses never overlap the phase where dir may change.

Test Plan:
1. dx=3, dy=0, period=10, raise go:
   - dir_x=1, dir_y=1.
   - Three step_x pulses, each 4 cycles wide, rising edges 10 cycles apart.
   - step_y stays 0.
   - After 30 RUN cycles: io_we=1, io_wreg=4, io_wdata=1.
   - Ack 1 cycle -> busy=0.
2. dx=-4, dy=2, period=8:
   - dir_x=0, dir_y=1.
   - step_x pulses on ticks 1-4.
   - step_y pulses on ticks 2 and 4 only.
   - RUN lasts 32 cycles.
3. dx=0, dy=0:
   - LOAD goes directly to WB; no step pulses.
   - io_we asserts the cycle after LOAD.
4. dx=2, dy=-2, period=2:
   - Tick spacing is clamped to 8 cycles.
   - Both axes step every tick; dir_y=0.
5. Assert ctrl_reset mid-RUN with go held high:
   - All outputs go to 0 at once; the FSM stays IDLE.
   - After go is toggled 0->1, a new move starts.
6. Hold io_ack low for 5 WB cycles and toggle go during RUN and WB:
   - io_we, io_wreg and io_wdata stay stable throughout.
   - No new move starts; return to IDLE only after io_ack goes high.
